// File: rtl/hyper_pipe_skid_rx_pkg.sv
// rtl/hyper_pipe_skid_rx_pkg.sv - shared types and threshold helper for the receive skid buffer
package hyper_pipe_skid_rx_pkg;

    localparam int ETH_DWIDTH = 512;
    localparam int ETH_EWIDTH = 6;

    typedef struct packed {
        logic                  sop;
        logic                  eop;
        logic                  err;
        logic [ETH_EWIDTH-1:0] empty;
        logic [ETH_DWIDTH-1:0] data;
    } eth_beat_t;

    typedef enum logic [1:0] {
        IDLE,
        IN_PKT,
        DROP
    } rx_state_t;

    // Leave room for every beat launched during the almost_full round trip.
    function automatic int af_thresh(input int depth, input int pipe_lat, input int af_margin);
        return depth - 2 * pipe_lat - af_margin - 1;
    endfunction

endpackage

// File: rtl/hyper_pipe_skid_rx_fifo.sv
// rtl/hyper_pipe_skid_rx_fifo.sv - circular buffer with registered first-word-fall-through head
module skid_fifo_fwft #(
    parameter int W     = 521,
    parameter int DEPTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [W-1:0]             din,
    input  logic                     pop,
    output logic [W-1:0]             dout,
    output logic                     dout_valid,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] rd_ptr_next;
    logic [CW-1:0] count_next;
    logic [W-1:0]  head_next;

    // The new head is either already in the array or is the beat being written this edge.
    always_comb begin
        rd_ptr_next = pop ? rd_ptr + 1'b1 : rd_ptr;
        count_next  = count + CW'(push) - CW'(pop);
        if (push && (wr_ptr == rd_ptr_next)) begin
            head_next = din;
        end else begin
            head_next = mem[rd_ptr_next];
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            dout_valid <= 1'b0;
            dout       <= '0;
        end else begin
            wr_ptr     <= wr_ptr + AW'(push);
            rd_ptr     <= rd_ptr_next;
            count      <= count_next;
            dout_valid <= (count_next != '0);
            if ((pop || (count == '0)) && (count_next != '0)) begin
                dout <= head_next;
            end
        end
    end

endmodule

// File: rtl/hyper_pipe_skid_rx.sv
// rtl/hyper_pipe_skid_rx.sv - receive skid buffer absorbing in-flight beats behind almost_full
module hyper_pipe_skid_rx
    import hyper_pipe_skid_rx_pkg::*;
#(
    parameter int DWIDTH    = ETH_DWIDTH,
    parameter int EWIDTH    = ETH_EWIDTH,
    parameter int DEPTH     = 32,
    parameter int PIPE_LAT  = 1,
    parameter int AF_MARGIN = 2,
    parameter int AF_THRESH = af_thresh(DEPTH, PIPE_LAT, AF_MARGIN)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_sop,
    input  logic                     in_eop,
    input  logic [DWIDTH-1:0]        in_data,
    input  logic [EWIDTH-1:0]        in_empty,
    input  logic                     in_valid,
    output logic                     in_almost_full,
    output logic                     out_sop,
    output logic                     out_eop,
    output logic [DWIDTH-1:0]        out_data,
    output logic [EWIDTH-1:0]        out_empty,
    output logic                     out_err,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   occupancy,
    output logic [31:0]              drop_cnt,
    output logic                     overflow
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int W  = DWIDTH + EWIDTH + 3;
    localparam logic [CW:0] ONE = 1;
    localparam logic [CW:0] TWO = 2;

    rx_state_t     state;
    rx_state_t     state_next;
    logic          pop;
    logic          push;
    logic          drop;
    logic          force_term;
    logic [CW:0]   avail;
    logic [CW-1:0] occ_next;
    logic [W-1:0]  wr_beat;
    logic [W-1:0]  head_beat;

    assign pop      = out_valid & out_ready;
    assign avail    = (CW+1)'(DEPTH) - {1'b0, occupancy} + (CW+1)'(pop);
    assign occ_next = occupancy + CW'(push) - CW'(pop);

    // A packet that runs out of room is closed on its last storable beat.
    assign wr_beat = {in_sop, in_eop | force_term, force_term,
                      force_term ? {EWIDTH{1'b0}} : in_empty, in_data};
    assign {out_sop, out_eop, out_err, out_empty, out_data} = head_beat;

    always_comb begin
        state_next = state;
        push       = 1'b0;
        drop       = 1'b0;
        force_term = 1'b0;
        if (in_valid) begin
            case (state)
                IDLE: begin
                    if (!in_sop) begin
                        drop = 1'b1;
                    end else if (in_eop) begin
                        if (avail >= ONE) push = 1'b1;
                        else              drop = 1'b1;
                    end else if (avail >= TWO) begin
                        push       = 1'b1;
                        state_next = IN_PKT;
                    end else begin
                        drop       = 1'b1;
                        state_next = DROP;
                    end
                end
                IN_PKT: begin
                    if (in_eop) begin
                        state_next = IDLE;
                        if (avail >= ONE) push = 1'b1;
                        else              drop = 1'b1;
                    end else if (avail >= TWO) begin
                        push = 1'b1;
                    end else if (avail == ONE) begin
                        push       = 1'b1;
                        force_term = 1'b1;
                        state_next = DROP;
                    end else begin
                        drop       = 1'b1;
                        state_next = DROP;
                    end
                end
                DROP: begin
                    drop = 1'b1;
                    if (in_eop) state_next = IDLE;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            in_almost_full <= 1'b0;
            drop_cnt       <= '0;
            overflow       <= 1'b0;
        end else begin
            state          <= state_next;
            in_almost_full <= (occ_next >= CW'(AF_THRESH));
            if (drop) begin
                overflow <= 1'b1;
                if (drop_cnt != 32'hFFFF_FFFF) drop_cnt <= drop_cnt + 32'd1;
            end
        end
    end

    skid_fifo_fwft #(
        .W     (W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .din        (wr_beat),
        .pop        (pop),
        .dout       (head_beat),
        .dout_valid (out_valid),
        .count      (occupancy)
    );

endmodule

// File: tb/tb_hyper_pipe_skid_rx.sv
// tb/tb_hyper_pipe_skid_rx.sv - scoreboard bench for the receive skid buffer
module tb_hyper_pipe_skid_rx;
    import hyper_pipe_skid_rx_pkg::*;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_sop = 1'b0;
    logic         in_eop = 1'b0;
    logic [511:0] in_data = '0;
    logic [5:0]   in_empty = '0;
    logic         in_valid = 1'b0;
    logic         in_almost_full;
    logic         out_sop;
    logic         out_eop;
    logic [511:0] out_data;
    logic [5:0]   out_empty;
    logic         out_err;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [5:0]   occupancy;
    logic [31:0]  drop_cnt;
    logic         overflow;

    int checks = 0;
    int errors = 0;
    eth_beat_t exp_q[$];
    eth_beat_t mon_e;

    hyper_pipe_skid_rx dut (
        .clk(clk), .rst(rst),
        .in_sop(in_sop), .in_eop(in_eop), .in_data(in_data), .in_empty(in_empty),
        .in_valid(in_valid), .in_almost_full(in_almost_full),
        .out_sop(out_sop), .out_eop(out_eop), .out_data(out_data), .out_empty(out_empty),
        .out_err(out_err), .out_valid(out_valid), .out_ready(out_ready),
        .occupancy(occupancy), .drop_cnt(drop_cnt), .overflow(overflow)
    );

    always #5 clk = ~clk;

    function automatic logic [511:0] mkd(input int id);
        return {16{32'(id) ^ 32'h5A00_0000}};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic expect_beat(input logic s, input logic e, input logic er,
                               input logic [5:0] emp, input logic [511:0] d);
        eth_beat_t b;
        b.sop = s; b.eop = e; b.err = er; b.empty = emp; b.data = d;
        exp_q.push_back(b);
    endtask

    task automatic beat(input logic s, input logic e, input logic [5:0] emp, input logic [511:0] d);
        in_valid = 1'b1; in_sop = s; in_eop = e; in_empty = emp; in_data = d;
        @(posedge clk); #1;
        in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic drain(input string nm, input int maxc);
        int n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < maxc) begin
            @(posedge clk); #1;
            n++;
        end
        chk(nm, (exp_q.size() == 0) && !out_valid, 1);
    endtask

    // Monitor: every beat handed to the consumer must match the next expected beat.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_beat actual data=%0h required none", out_data[31:0]);
            end else begin
                mon_e = exp_q.pop_front();
                if ({out_sop, out_eop, out_err, out_empty, out_data} !== mon_e) begin
                    errors++;
                    $display("FAIL out_beat actual sop=%0b eop=%0b err=%0b empty=%0d data=%0h required sop=%0b eop=%0b err=%0b empty=%0d data=%0h",
                             out_sop, out_eop, out_err, out_empty, out_data[31:0],
                             mon_e.sop, mon_e.eop, mon_e.err, mon_e.empty, mon_e.data[31:0]);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int i;
        int sent_after;
        int stored;
        int n;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", out_valid, 0);
        chk("rst_occ", occupancy, 0);
        chk("rst_af", in_almost_full, 0);
        chk("rst_drop", drop_cnt, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_outs", {out_sop, out_eop, out_err, out_empty, out_data}, 0);
        rst = 1'b0;
        idle(1);

        // Single-beat packet, one-cycle latency.
        out_ready = 1'b1;
        expect_beat(1, 1, 0, 5, mkd(1));
        beat(1, 1, 5, mkd(1));
        chk("t1_lat_valid", out_valid, 1);
        chk("t1_lat_data", out_data[63:0], mkd(1) & 512'hFFFF_FFFF_FFFF_FFFF);
        chk("t1_err", out_err, 0);
        idle(1);
        chk("t1_occ", occupancy, 0);

        // 40-beat packet, sender obeys almost_full with 3 beats of skid.
        out_ready = 1'b0;
        i = 1; sent_after = -1; stored = 0;
        while (i <= 40 && sent_after < 3) begin
            expect_beat(i == 1, i == 40, 0, 0, mkd(99 + i));
            beat(i == 1, i == 40, 0, mkd(99 + i));
            stored++;
            chk("t2_occ", occupancy, stored);
            chk("t2_af", in_almost_full, stored >= 27);
            if (sent_after >= 0) sent_after++;
            else if (in_almost_full) sent_after = 0;
            i++;
        end
        idle(2);
        out_ready = 1'b1;
        n = 0;
        while (i <= 40 && n < 400) begin
            if (in_almost_full) begin
                idle(1);
            end else begin
                expect_beat(i == 1, i == 40, 0, 0, mkd(99 + i));
                beat(i == 1, i == 40, 0, mkd(99 + i));
                i++;
            end
            n++;
        end
        chk("t2_all_sent", i, 41);
        drain("t2_drain", 200);
        chk("t2_drop", drop_cnt, 0);
        chk("t2_ovf", overflow, 0);

        // Same packet, sender ignores almost_full: truncation at beat 32.
        out_ready = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            if (k <= 31) expect_beat(k == 1, 0, 0, 0, mkd(199 + k));
            else if (k == 32) expect_beat(0, 1, 1, 0, mkd(199 + k));
            beat(k == 1, k == 40, (k == 40) ? 6'd3 : 6'd0, mkd(199 + k));
        end
        chk("t3_drop", drop_cnt, 8);
        chk("t3_ovf", overflow, 1);
        chk("t3_occ", occupancy, 32);
        out_ready = 1'b1;
        drain("t3_drain", 100);
        expect_beat(1, 0, 0, 0, mkd(300));
        expect_beat(0, 1, 0, 4, mkd(301));
        beat(1, 0, 0, mkd(300));
        beat(0, 1, 4, mkd(301));
        drain("t3_next_pkt", 20);
        chk("t3_drop_after", drop_cnt, 8);

        // Full buffer: push and pop on the same edge.
        out_ready = 1'b0;
        for (int k = 0; k < 32; k++) begin
            expect_beat(1, 1, 0, 6'(k), mkd(400 + k));
            beat(1, 1, 6'(k), mkd(400 + k));
        end
        chk("t4_full_occ", occupancy, 32);
        chk("t4_full_af", in_almost_full, 1);
        out_ready = 1'b1;
        expect_beat(1, 1, 0, 7, mkd(432));
        beat(1, 1, 7, mkd(432));
        chk("t4_pushpop_occ", occupancy, 32);
        chk("t4_pushpop_drop", drop_cnt, 8);
        drain("t4_drain", 100);

        // Reset mid-packet with 10 beats stored.
        out_ready = 1'b0;
        for (int k = 0; k < 10; k++) beat(k == 0, 0, 0, mkd(500 + k));
        chk("t5_occ_before", occupancy, 10);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("t5_valid", out_valid, 0);
        chk("t5_occ", occupancy, 0);
        chk("t5_af", in_almost_full, 0);
        chk("t5_drop", drop_cnt, 0);
        chk("t5_ovf", overflow, 0);

        // Non-sop beat while IDLE is dropped.
        out_ready = 1'b1;
        beat(0, 0, 0, mkd(600));
        idle(3);
        chk("t6_drop", drop_cnt, 1);
        chk("t6_ovf", overflow, 1);
        chk("t6_occ", occupancy, 0);
        chk("t6_valid", out_valid, 0);
        chk("final_queue_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
